// File: rtl/prng_pkg.sv
// Shared types, register offsets and the xorshift32 step for the PRNG bank.
package prng_pkg;

    typedef enum logic [1:0] {
        MANUAL    = 2'd0,
        AUTO_READ = 2'd1,
        FREE_RUN  = 2'd2,
        RSVD      = 2'd3
    } prng_mode_e;

    // Word offsets within a channel's 16-byte window (addr[3:2])
    localparam logic [1:0] REG_CTRL  = 2'h0;
    localparam logic [1:0] REG_SEED  = 2'h1;
    localparam logic [1:0] REG_VALUE = 2'h2;
    localparam logic [1:0] REG_TRIG  = 2'h3;

    localparam logic [31:0] GOLDEN_RATIO = 32'h9E3779B9;

    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] t;
        t = x;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // Reset seed of channel k: base ^ (k * golden ratio), truncated to 32 bits
    function automatic logic [31:0] channel_seed(input logic [31:0] base, input int unsigned k);
        logic [31:0] kk;
        kk = 32'(k);
        return base ^ (kk * GOLDEN_RATIO);
    endfunction

endpackage

// File: rtl/prng_bank_if.sv
// OBI subordinate bus bundle for the PRNG bank.
interface prng_bank_if #(
    parameter int unsigned IdWidth = 4
) ();
    logic               req_i;
    logic               we_i;
    logic [3:0]         be_i;
    logic [31:0]        addr_i;
    logic [31:0]        wdata_i;
    logic [IdWidth-1:0] aid_i;
    logic               gnt_o;
    logic               rvalid_o;
    logic [31:0]        rdata_o;
    logic [IdWidth-1:0] rid_o;
    logic               err_o;

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, aid_i,
        output gnt_o, rvalid_o, rdata_o, rid_o, err_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, aid_i,
        input  gnt_o, rvalid_o, rdata_o, rid_o, err_o
    );
endinterface

// File: rtl/prng_channel.sv
// One xorshift32 channel: state, advance counter and control register.
module prng_channel
    import prng_pkg::*;
#(
    parameter logic [31:0] SEED_RST = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ctrl_we_i,
    input  logic [2:0]  ctrl_wdata_i,
    input  logic        seed_we_i,
    input  logic [31:0] seed_i,
    input  logic        trig_i,
    input  logic        value_rd_i,
    output logic [31:0] state_o,
    output logic [31:0] count_o,
    output logic [2:0]  ctrl_o
);

    if (SEED_RST == 32'h0) begin : gen_seed_chk
        $fatal(1, "prng_channel: reset seed must be nonzero");
    end

    logic [31:0] state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        adv;
    prng_mode_e  mode;

    assign mode = prng_mode_e'(ctrl_q[1:0]);

    // Advance request from the current mode; several sources still mean one step
    always_comb begin
        adv = 1'b0;
        if (ctrl_q[2]) begin
            unique case (mode)
                MANUAL:    adv = trig_i;
                AUTO_READ: adv = trig_i | value_rd_i;
                FREE_RUN:  adv = 1'b1;
                default:   adv = 1'b0;
            endcase
        end
    end

    // Next state: seed load wins over any step
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ctrl_d  = ctrl_we_i ? ctrl_wdata_i : ctrl_q;
        if (seed_we_i) begin
            state_d = seed_i;
            count_d = 32'h0;
        end else if (adv) begin
            state_d = xorshift32_step(state_q);
            count_d = count_q + 32'h1;
        end
    end

    // Channel registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED_RST;
            count_q <= 32'h0;
            ctrl_q  <= 3'b100;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign state_o = state_q;
    assign count_o = count_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/prng_bank.sv
// Multi-channel xorshift32 peripheral: OBI decode, error check and response register.
module prng_bank
    import prng_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter logic [31:0] SEED_DEFAULT = 32'hDEADBEEF,
    parameter int unsigned IdWidth      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    prng_bank_if.slave             bus,
    output logic [NUM_CH*32-1:0]   prn_o
);

    localparam int unsigned CH_ADDR_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || NUM_CH > 16) begin : gen_num_ch_chk
        $fatal(1, "prng_bank: NUM_CH must be in 1..16");
    end

    logic [27:0]             ch_idx;
    logic [CH_ADDR_BITS-1:0] ch_sel;
    logic [1:0]              off;
    logic                    ch_ok;
    logic                    err;
    logic                    valid;
    logic [NUM_CH-1:0]       hit;
    logic [31:0]             rdata_d;
    logic                    unused_addr;

    logic [31:0] ch_state [NUM_CH];
    logic [31:0] ch_count [NUM_CH];
    logic [2:0]  ch_ctrl  [NUM_CH];

    logic               rvalid_q;
    logic [31:0]        rdata_q;
    logic [IdWidth-1:0] rid_q;
    logic               err_q;

    // The full upper address is the channel index so aliases above NUM_CH error out
    assign ch_idx      = bus.addr_i[31:4];
    assign ch_sel      = bus.addr_i[CH_ADDR_BITS+3:4];
    assign off         = bus.addr_i[3:2];
    assign ch_ok       = ch_idx < 28'(NUM_CH);
    assign unused_addr = ^bus.addr_i[1:0];

    // Access error classification
    always_comb begin
        err = !ch_ok;
        if (bus.we_i) begin
            if (bus.be_i != 4'hF)                                err = 1'b1;
            if (off == REG_VALUE)                                err = 1'b1;
            if (off == REG_SEED && bus.wdata_i == 32'h0)         err = 1'b1;
            if (off == REG_CTRL && bus.wdata_i[1:0] == 2'b11)    err = 1'b1;
        end else if (off == REG_SEED) begin
            err = 1'b1;
        end
    end

    assign valid     = bus.req_i & ~err;
    assign bus.gnt_o = bus.req_i;

    for (genvar k = 0; k < NUM_CH; k++) begin : gen_ch
        assign hit[k] = valid && (ch_sel == CH_ADDR_BITS'(k));

        prng_channel #(
            .SEED_RST (channel_seed(SEED_DEFAULT, k))
        ) u_ch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .ctrl_we_i    (hit[k] & bus.we_i & (off == REG_CTRL)),
            .ctrl_wdata_i (bus.wdata_i[2:0]),
            .seed_we_i    (hit[k] & bus.we_i & (off == REG_SEED)),
            .seed_i       (bus.wdata_i),
            .trig_i       (hit[k] & bus.we_i & (off == REG_TRIG)),
            .value_rd_i   (hit[k] & ~bus.we_i & (off == REG_VALUE)),
            .state_o      (ch_state[k]),
            .count_o      (ch_count[k]),
            .ctrl_o       (ch_ctrl[k])
        );

        assign prn_o[32*k +: 32] = ch_state[k];
    end

    // Read mux; pre-update register values, zero for writes and errors
    always_comb begin
        rdata_d = 32'h0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (hit[k] && !bus.we_i) begin
                unique case (off)
                    REG_CTRL:  rdata_d = {29'h0, ch_ctrl[k]};
                    REG_VALUE: rdata_d = ch_state[k];
                    REG_TRIG:  rdata_d = ch_count[k];
                    default:   rdata_d = 32'h0;
                endcase
            end
        end
    end

    // Response register: one cycle after grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            rid_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= bus.req_i;
            rdata_q  <= rdata_d;
            err_q    <= bus.req_i & err;
            if (bus.req_i) begin
                rid_q <= bus.aid_i;
            end
        end
    end

    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.rid_o    = rid_q;
    assign bus.err_o    = err_q;

endmodule

// File: doc/prng_bank.md
Name: prng_bank

Overview:
Multi-channel xorshift32 pseudo-random number peripheral on the user-domain OBI subordinate bus. Each of NUM_CH independent channels has its own seed, mode, state and draw counter. It adds three behaviours to the single-channel trigger-only generator: software seeding, auto-advance-on-read and free-running modes. All channel states are also exported as a flat vector for hardware consumers.

Parameters:
NUM_CH, 4, number of independent generator channels (1..16)
SEED_DEFAULT, 32'hDEADBEEF, reset seed of channel 0; channel k resets to SEED_DEFAULT ^ (k * 32'h9E3779B9), and must be nonzero (elaboration assertion)
CH_ADDR_BITS, $clog2(NUM_CH) (min 1), channel-select width taken from addr_i[CH_ADDR_BITS+3:4]

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  OBI request
we_i  in  1  write enable
be_i  in  4  byte enables
addr_i  in  32  byte address
wdata_i  in  32  write data
aid_i  in  SbrObiCfg.IdWidth  transaction ID
gnt_o  out  1  grant
rvalid_o  out  1  response valid
rdata_o  out  32  read data
rid_o  out  SbrObiCfg.IdWidth  response ID
err_o  out  1  response error
prn_o  out  NUM_CH*32  current state of every channel; channel k occupies [32k+31:32k]

Behaviour:
- One clock domain: clk_i. rst_ni is asynchronous and active-low.
- Generator step: x ^= x<<13; x ^= x>>17; x ^= x<<5. All arithmetic is 32-bit and truncating.
- Register map per channel, 16-byte stride:
  - 0x0 CTRL (RW): [1:0] mode, [2] enable. Mode 0 MANUAL, 1 AUTO_READ, 2 FREE_RUN, 3 reserved.
  - 0x4 SEED (W): loads the state.
  - 0x8 VALUE (R): returns the current state.
  - 0xC TRIG/COUNT: write means advance; read returns the 32-bit advance count.
- Handshake:
  - gnt_o = req_i (combinational, always accepted).
  - Response arrives exactly 1 cycle after grant: rvalid_o=1, rid_o=latched aid_i.
  - rdata_o is registered from the accept cycle and is 0 for writes and errors.
  - Back-to-back requests every cycle are supported.
- Errors (err_o=1 in the response cycle, no state change):
  - channel index >= NUM_CH
  - write to VALUE, read of SEED
  - write with be_i != 4'hF
  - SEED write of 0
  - CTRL write with mode 3
- Advance sources for channel k, evaluated only when enable=1:
  - MANUAL: valid TRIG write.
  - AUTO_READ: valid VALUE read (rdata carries the pre-advance state) or TRIG write.
  - FREE_RUN: every cycle.
- Simultaneous events:
  - A SEED write has priority over any advance in the same cycle.
  - Multiple advance sources in one cycle give exactly one step.
- COUNT:
  - increments by 1 per step and wraps 0xFFFFFFFF -> 0
  - clears to 0 on SEED write
  - a COUNT read in the same cycle as a step returns the pre-increment value
- With enable=0 the state is frozen. SEED and CTRL writes still work; TRIG writes are accepted without error and have no effect.
- Reset values:
  - state[k] = per-channel seed; COUNT = 0; CTRL = 0x4 (enabled, MANUAL).
  - rvalid_o=0, err_o=0, rdata_o=0, rid_o=0; prn_o = reset seeds.
- Reset asserted mid-transaction drops any pending response; no rvalid_o after reset release.
- prn_o reflects the registered state (state_q), with no combinational path from the bus.

Decomposition:
- Shared package prng_pkg holds:
  - prng_mode_e (MANUAL, AUTO_READ, FREE_RUN, RSVD)
  - register offset localparams (CTRL=2'h0, SEED=2'h1, VALUE=2'h2, TRIG=2'h3)
  - golden ratio constant 32'h9E3779B9
  - function xorshift32_step
- One sub-module, prng_channel: holds the state, COUNT and CTRL registers for one channel, plus the advance and seed priority logic. It is instantiated NUM_CH times via generate.
- The top level holds the OBI decode, the error logic and the response register.

Test Plan:
- Reset, then read ch0 VALUE (0x008) -> rdata 0xDEADBEEF, err 0. Read ch1 VALUE (0x018) -> 0xDEADBEEF^0x9E3779B9 = 0x409AC756.
- ch0: write SEED=1, TRIG, TRIG, then read VALUE and COUNT -> 0x04080601 and 2. Intermediate VALUE after the first TRIG = 0x00042021.
- ch1: CTRL=0x5 (AUTO_READ), SEED=1, two VALUE reads -> 0x00000001 then 0x00042021; COUNT=2.
- ch2: CTRL=0x6 (FREE_RUN), SEED=1, wait 10 cycles, then CTRL=0x2 (disable). Two COUNT reads are equal and nonzero; VALUE equals prn_o[95:64]; ch0 is unaffected.
- Errors, each with err 1 and no state change:
  - SEED=0
  - CTRL mode 3
  - be_i=4'h3 write
  - read 0x004
  - access to channel NUM_CH
- Back-to-back reads with aid 3,4,5 every cycle -> rvalid three consecutive cycles, rid 3,4,5. Reset pulse mid-burst -> rvalid 0 and all registers at reset values.
